// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared 64-point radix-4 FFT constants, digit reversal and twiddle generation
package fft_pkg;

  localparam int FFT_N      = 64;
  localparam int FFT_STAGES = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CALC,
    ST_OUT
  } fft_state_t;

  function automatic logic [5:0] digit_rev4(input logic [5:0] n);
    return {n[1:0], n[3:2], n[5:4]};
  endfunction

  // cos (use_sin=0) or sin (use_sin=1) of 2*pi*m/64, +1.0 coded as 2^(tw_width-2)
  function automatic int tw_gen(input int m, input int tw_width, input bit use_sin);
    real one;
    real ang;
    real v;
    int  r;
    int  lim;
    lim = 1 << (tw_width - 2);
    one = real'(lim);
    ang = 6.283185307179586 * real'(m) / real'(FFT_N);
    v   = (use_sin ? $sin(ang) : $cos(ang)) * one;
    r   = int'($floor(v + 0.5));
    if (r > lim)  r = lim;
    if (r < -lim) r = -lim;
    return r;
  endfunction

endpackage

// File: rtl/ifft_n64_base_n4_if.sv
// rtl/ifft_n64_base_n4_if.sv - spectrum-in / time-samples-out bus of the 64-point inverse FFT
interface ifft_n64_base_n4_if #(
  parameter int DATA_WIDTH = 32
);

  logic                         data_in_pluse_i;
  logic signed [DATA_WIDTH:0]   xk_real_i;
  logic signed [DATA_WIDTH:0]   xk_imag_i;
  logic                         in_ready_o;
  logic                         data_out_pluse_o;
  logic signed [DATA_WIDTH-1:0] xn_real_o;
  logic signed [DATA_WIDTH-1:0] xn_imag_o;

  modport master (
    output data_in_pluse_i, xk_real_i, xk_imag_i,
    input  in_ready_o, data_out_pluse_o, xn_real_o, xn_imag_o
  );

  modport slave (
    input  data_in_pluse_i, xk_real_i, xk_imag_i,
    output in_ready_o, data_out_pluse_o, xn_real_o, xn_imag_o
  );

endinterface

// File: rtl/fft_r4_bfly_inv.sv
// rtl/fft_r4_bfly_inv.sv - registered twiddle multiply plus combinational inverse radix-4 butterfly with 1/4 scaling
module fft_r4_bfly_inv #(
  parameter int IW       = 34,
  parameter int TW_WIDTH = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic signed [IW-1:0]       x_re [4],
  input  logic signed [IW-1:0]       x_im [4],
  input  logic signed [TW_WIDTH-1:0] w_re [1:3],
  input  logic signed [TW_WIDTH-1:0] w_im [1:3],
  output logic signed [IW-1:0]       y_re [4],
  output logic signed [IW-1:0]       y_im [4]
);

  localparam int PW = IW + TW_WIDTH + 1;
  localparam int SW = IW + 2;

  logic signed [IW-1:0] p_re [4];
  logic signed [IW-1:0] p_im [4];
  logic signed [SW-1:0] ar, ai, br, bi, cr, ci, dr, di;

  function automatic logic signed [IW-1:0] rnd(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] t;
    t = (p + (PW'(1) <<< (TW_WIDTH - 3))) >>> (TW_WIDTH - 2);
    return t[IW-1:0];
  endfunction

  function automatic logic signed [IW-1:0] sc(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] t;
    t = s >>> 2;
    return t[IW-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        p_re[k] <= '0;
        p_im[k] <= '0;
      end
    end else if (load) begin
      p_re[0] <= x_re[0];
      p_im[0] <= x_im[0];
      for (int k = 1; k < 4; k++) begin
        p_re[k] <= rnd(PW'(x_re[k]) * PW'(w_re[k]) - PW'(x_im[k]) * PW'(w_im[k]));
        p_im[k] <= rnd(PW'(x_re[k]) * PW'(w_im[k]) + PW'(x_im[k]) * PW'(w_re[k]));
      end
    end
  end

  // Legs use +j rotations: this is the inverse transform kernel
  always_comb begin
    ar = SW'(p_re[0]); ai = SW'(p_im[0]);
    br = SW'(p_re[1]); bi = SW'(p_im[1]);
    cr = SW'(p_re[2]); ci = SW'(p_im[2]);
    dr = SW'(p_re[3]); di = SW'(p_im[3]);
    y_re[0] = sc(ar + br + cr + dr);
    y_im[0] = sc(ai + bi + ci + di);
    y_re[1] = sc(ar - bi - cr + di);
    y_im[1] = sc(ai + br - ci - dr);
    y_re[2] = sc(ar - br + cr - dr);
    y_im[2] = sc(ai - bi + ci - di);
    y_re[3] = sc(ar + bi - cr - di);
    y_im[3] = sc(ai - br - ci + dr);
  end

endmodule

// File: rtl/ifft_n64_base_n4.sv
// rtl/ifft_n64_base_n4.sv - 64-point in-place radix-4 inverse FFT with one butterfly engine
module ifft_n64_base_n4
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TW_WIDTH   = 18
) (
  input  logic               sys_clk_i,
  input  logic               rst_i,
  ifft_n64_base_n4_if.slave  bus
);

  localparam int IW = DATA_WIDTH + 2;

  fft_state_t state, state_nxt;
  logic [6:0] cnt, cnt_nxt;

  logic signed [IW-1:0]       mem_re [FFT_N];
  logic signed [IW-1:0]       mem_im [FFT_N];
  logic signed [TW_WIDTH-1:0] rom_re [FFT_N];
  logic signed [TW_WIDTH-1:0] rom_im [FFT_N];

  logic [1:0] stage;
  logic [3:0] bfly;
  logic [5:0] a0, step, jm, load_addr;
  logic [5:0] addr [4];
  logic       load_we, calc_a, calc_b;

  logic signed [IW-1:0]       x_re [4];
  logic signed [IW-1:0]       x_im [4];
  logic signed [IW-1:0]       y_re [4];
  logic signed [IW-1:0]       y_im [4];
  logic signed [TW_WIDTH-1:0] w_re [1:3];
  logic signed [TW_WIDTH-1:0] w_im [1:3];

  for (genvar m = 0; m < FFT_N; m++) begin : g_rom
    localparam int C = tw_gen(m, TW_WIDTH, 1'b0);
    localparam int S = tw_gen(m, TW_WIDTH, 1'b1);
    assign rom_re[m] = TW_WIDTH'(C);
    assign rom_im[m] = TW_WIDTH'(S);
  end

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [IW-1:0] v);
    if (v[IW-1:DATA_WIDTH-1] == {(IW-DATA_WIDTH+1){v[IW-1]}})
      return v[DATA_WIDTH-1:0];
    return v[IW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction

  assign bus.in_ready_o = (state == ST_IDLE);

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: if (bus.data_in_pluse_i) begin
        state_nxt = ST_LOAD;
        cnt_nxt   = 7'd1;
      end
      ST_LOAD: begin
        cnt_nxt = cnt + 7'd1;
        if (cnt == 7'd63) begin
          state_nxt = ST_CALC;
          cnt_nxt   = '0;
        end
      end
      ST_CALC: begin
        cnt_nxt = cnt + 7'd1;
        if (cnt == 7'd95) begin
          state_nxt = ST_OUT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        cnt_nxt = cnt + 7'd1;
        if (cnt == 7'd63) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
    endcase
  end

  // During CALC the counter reads as {stage, butterfly, phase}
  assign stage     = cnt[6:5];
  assign bfly      = cnt[4:1];
  assign calc_a    = (state == ST_CALC) && !cnt[0];
  assign calc_b    = (state == ST_CALC) && cnt[0];
  assign load_we   = ((state == ST_IDLE) && bus.data_in_pluse_i) || (state == ST_LOAD);
  assign load_addr = digit_rev4(cnt[5:0]);

  always_comb begin
    a0   = '0;
    step = 6'd1;
    jm   = '0;
    case (stage)
      2'd0: begin
        a0   = {bfly, 2'b00};
        step = 6'd1;
        jm   = '0;
      end
      2'd1: begin
        a0   = {bfly[3:2], 2'b00, bfly[1:0]};
        step = 6'd4;
        jm   = {2'b00, bfly[1:0], 2'b00};
      end
      default: begin
        a0   = {2'b00, bfly};
        step = 6'd16;
        jm   = {2'b00, bfly};
      end
    endcase
    for (int k = 0; k < 4; k++) begin
      addr[k] = a0 + 6'(k) * step;
      x_re[k] = mem_re[addr[k]];
      x_im[k] = mem_im[addr[k]];
    end
    for (int k = 1; k < 4; k++) begin
      w_re[k] = rom_re[6'(k) * jm];
      w_im[k] = rom_im[6'(k) * jm];
    end
  end

  fft_r4_bfly_inv #(.IW(IW), .TW_WIDTH(TW_WIDTH)) u_bfly (
    .clk  (sys_clk_i),
    .rst  (rst_i),
    .load (calc_a),
    .x_re (x_re),
    .x_im (x_im),
    .w_re (w_re),
    .w_im (w_im),
    .y_re (y_re),
    .y_im (y_im)
  );

  always_ff @(posedge sys_clk_i) begin
    if (load_we) begin
      mem_re[load_addr] <= IW'(bus.xk_real_i);
      mem_im[load_addr] <= IW'(bus.xk_imag_i);
    end else if (calc_b) begin
      for (int k = 0; k < 4; k++) begin
        mem_re[addr[k]] <= y_re[k];
        mem_im[addr[k]] <= y_im[k];
      end
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.xn_real_o        <= '0;
      bus.xn_imag_o        <= '0;
      bus.data_out_pluse_o <= 1'b0;
    end else if (state == ST_OUT) begin
      bus.xn_real_o        <= sat(mem_re[cnt[5:0]]);
      bus.xn_imag_o        <= sat(mem_im[cnt[5:0]]);
      bus.data_out_pluse_o <= (cnt == 7'd0);
    end else begin
      bus.xn_real_o        <= '0;
      bus.xn_imag_o        <= '0;
      bus.data_out_pluse_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifft_n64_base_n4.sv
// tb/tb_ifft_n64_base_n4.sv - self-checking bench for the 64-point inverse FFT against a direct IDFT
module tb_ifft_n64_base_n4;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  longint fr_re [64];
  longint fr_im [64];
  longint exp_re [64];
  longint exp_im [64];
  longint out_re [64];
  longint out_im [64];

  always #5 clk = ~clk;

  ifft_n64_base_n4_if #(.DATA_WIDTH(DW)) bus ();

  ifft_n64_base_n4 #(.DATA_WIDTH(DW), .TW_WIDTH(18)) dut (
    .sys_clk_i (clk),
    .rst_i     (rst),
    .bus       (bus)
  );

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    longint d;
    n_checks++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic longint clamp_r(input real v);
    if (v > 2147483647.0)  return 64'sd2147483647;
    if (v < -2147483648.0) return -64'sd2147483648;
    return longint'(v);
  endfunction

  // Direct IDFT with 1/64 scaling, saturated to the output width
  task automatic model();
    real sr, si, a;
    int  m;
    for (int n = 0; n < 64; n++) begin
      sr = 0.0;
      si = 0.0;
      for (int k = 0; k < 64; k++) begin
        m  = (k * n) % 64;
        a  = 6.283185307179586 * real'(m) / 64.0;
        sr = sr + real'(fr_re[k]) * $cos(a) - real'(fr_im[k]) * $sin(a);
        si = si + real'(fr_re[k]) * $sin(a) + real'(fr_im[k]) * $cos(a);
      end
      exp_re[n] = clamp_r(sr / 64.0);
      exp_im[n] = clamp_r(si / 64.0);
    end
  endtask

  task automatic clear_frame();
    for (int k = 0; k < 64; k++) begin
      fr_re[k] = 0;
      fr_im[k] = 0;
    end
  endtask

  task automatic random_frame();
    for (int k = 0; k < 64; k++) begin
      fr_re[k] = longint'($urandom_range(65535)) - 32768;
      fr_im[k] = longint'($urandom_range(65535)) - 32768;
    end
  endtask

  task automatic compare_frame(input string name, input longint tol);
    for (int i = 0; i < 64; i++) begin
      check($sformatf("%s re[%0d]", name, i), out_re[i], exp_re[i], tol);
      check($sformatf("%s im[%0d]", name, i), out_im[i], exp_im[i], tol);
    end
  endtask

  // Cycle c=0 is the pulse cycle; outputs are sampled on the falling edge
  task automatic run_frame(input string name, input int rst_at, input bit extra);
    int     t;
    int     pulse_cyc;
    int     npulse;
    int     rdy_bad;
    longint rdy_end;
    longint idle_re;
    t = 0;
    while (!bus.in_ready_o && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check({name, " ready_wait"}, longint'(bus.in_ready_o), 1, 0);
    pulse_cyc = -1;
    npulse    = 0;
    rdy_bad   = 0;
    rdy_end   = 0;
    idle_re   = -1;
    for (int c = 0; c < 240; c++) begin
      bus.data_in_pluse_i = (c == 0) || (extra && (c == 10 || c == 100 || c == 180));
      if (c < 64) begin
        bus.xk_real_i = 33'(fr_re[c]);
        bus.xk_imag_i = 33'(fr_im[c]);
      end else begin
        bus.xk_real_i = 33'($urandom);
        bus.xk_imag_i = 33'($urandom);
      end
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        check({name, " rst xn_real"}, longint'(bus.xn_real_o), 0, 0);
        check({name, " rst xn_imag"}, longint'(bus.xn_imag_o), 0, 0);
        check({name, " rst pulse"}, longint'(bus.data_out_pluse_o), 0, 0);
        check({name, " rst ready"}, longint'(bus.in_ready_o), 1, 0);
      end
      if (rst_at >= 0 && c == rst_at + 2) rst = 1'b0;
      @(negedge clk);
      if (bus.data_out_pluse_o) begin
        npulse++;
        if (pulse_cyc < 0) pulse_cyc = c;
      end
      if (c >= 1 && c <= 223 && (rst_at < 0 || c < rst_at) && bus.in_ready_o) rdy_bad++;
      if (c >= 161 && c <= 224) begin
        out_re[c-161] = longint'(bus.xn_real_o);
        out_im[c-161] = longint'(bus.xn_imag_o);
      end
      if (c == 224) rdy_end = longint'(bus.in_ready_o);
      if (c == 225) idle_re = longint'(bus.xn_real_o) | longint'(bus.xn_imag_o);
      @(posedge clk); #1;
    end
    bus.data_in_pluse_i = 1'b0;
    bus.xk_real_i       = '0;
    bus.xk_imag_i       = '0;
    check({name, " busy_not_ready"}, rdy_bad, 0, 0);
    if (rst_at < 0) begin
      check({name, " latency"}, pulse_cyc, 161, 0);
      check({name, " pulse_count"}, npulse, 1, 0);
      check({name, " ready_after_out"}, rdy_end, 1, 0);
      check({name, " idle_zero"}, idle_re, 0, 0);
    end else begin
      check({name, " no_pulse_after_rst"}, npulse, 0, 0);
    end
  endtask

  initial begin
    bus.data_in_pluse_i = 1'b0;
    bus.xk_real_i       = '0;
    bus.xk_imag_i       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", longint'(bus.in_ready_o), 1, 0);
    check("reset pulse", longint'(bus.data_out_pluse_o), 0, 0);
    check("reset xn_real", longint'(bus.xn_real_o), 0, 0);
    check("reset xn_imag", longint'(bus.xn_imag_o), 0, 0);
    rst = 1'b0;

    clear_frame();
    fr_re[0] = 64000;
    model();
    run_frame("impulse", -1, 1'b0);
    compare_frame("impulse", 0);

    clear_frame();
    fr_re[1] = 6400;
    model();
    run_frame("tone", -1, 1'b0);
    compare_frame("tone", 2);

    for (int f = 0; f < 4; f++) begin
      random_frame();
      model();
      run_frame($sformatf("rand%0d", f), -1, 1'b0);
      compare_frame($sformatf("rand%0d", f), 3);
    end

    random_frame();
    model();
    run_frame("pulses", -1, 1'b1);
    compare_frame("pulses", 3);

    clear_frame();
    for (int k = 0; k < 64; k++) fr_re[k] = 64'sd4294967295;
    model();
    run_frame("sat", -1, 1'b0);
    compare_frame("sat", 1);

    random_frame();
    run_frame("rst_calc", 120, 1'b0);

    clear_frame();
    fr_re[0] = 64000;
    model();
    run_frame("after_rst", -1, 1'b0);
    compare_frame("after_rst", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
